descramble_framer: RTL
======================

DESCRAMBLE_FRAMER -- requirements
Module: descramble_framer

Interface
REQ-001 Parameter SYNC_WORD, default 8'hA5, frame sync byte in the descrambled domain, MSB received first.
REQ-002 Parameter PAYLOAD_BYTES, default 4, payload bytes per frame (range 1..31).
REQ-003 Parameter LOCK_CNT, default 2, consecutive good syncs needed to enter LOCKED (range 1..7).
REQ-004 Parameter UNLOCK_CNT, default 2, consecutive bad syncs in LOCKED needed to return to HUNT (range 1..7).
REQ-005 Clk  in  1  clock; all state changes on its rising edge.
REQ-006 Reset  in  1  reset, asynchronous, active-high.
REQ-007 Din  in  1  scrambled serial bit from the scrambler's Out.
REQ-008 Din_Valid  in  1  Din is sampled only when high.
REQ-009 Dout  out  1  registered descrambled bit.
REQ-010 Dout_Valid  out  1  registered copy of Din_Valid, aligned with Dout.
REQ-011 Byte  out  8  registered payload byte, first-received bit in bit 7.
REQ-012 Byte_Valid  out  1  one-cycle pulse per payload byte, only in LOCKED.
REQ-013 Locked  out  1  high while the FSM is in LOCKED.
REQ-014 Sync_Err_Cnt  out  8  saturating count of sync mismatches.

Function
REQ-015 Descrambler: the history register h[4:0] resets to 5'b10101; with Din_Valid high, d = Din^h[4]^h[3]^h[1]^h[0] and h <= {h[3:0],Din}; with Din_Valid low, h holds.
REQ-016 Dout <= d and Dout_Valid <= 1 one cycle after a valid sample, giving one-cycle latency; when Din_Valid is low, Dout_Valid <= 0 and Dout holds.
REQ-017 The descrambler is self-synchronising: after 5 valid bits taken from a correct scrambled stream, d is correct regardless of the initial h.
REQ-018 Shift register sr[7:0] resets to 0; on each valid bit, sr_next = {sr[6:0], d} and sr <= sr_next; all comparisons below use sr_next.
REQ-019 Bit counter c: range 0..F-1, where F = 8*(PAYLOAD_BYTES+1); it advances only on valid bits and wraps from F-1 to 0; positions 0..8*PAYLOAD_BYTES-1 are payload and the last 8 positions are sync.
REQ-020 FSM states are HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-021 HUNT: on every valid bit, if sr_next == SYNC_WORD, set c <= 0 and good <= 1; then, if LOCK_CNT == 1, go to LOCKED, otherwise go to VERIFY.
REQ-022 VERIFY: at c == F-1, if sr_next == SYNC_WORD, increment good; when good reaches LOCK_CNT, go to LOCKED, otherwise stay in VERIFY. On a mismatch, go to HUNT. Byte_Valid stays low.
REQ-023 LOCKED: at a valid bit with c < 8*PAYLOAD_BYTES and c%8 == 7, Byte <= sr_next and Byte_Valid pulses high the next cycle.
REQ-024 LOCKED: at c == F-1, a match clears bad; a mismatch increments bad. When bad reaches UNLOCK_CNT, go to HUNT, otherwise stay in LOCKED (flywheel, bytes keep flowing).
REQ-025 Every sync mismatch in VERIFY or LOCKED increments Sync_Err_Cnt, which saturates at 255 and does not wrap.
REQ-026 Locked is registered and changes in the same cycle as the state register.
REQ-027 On an exit to HUNT, the next search begins with the following valid bit; sr is not cleared.
REQ-028 When Din_Valid is low, the FSM, c, sr, good and bad all hold, and Byte_Valid is 0.

Reset
REQ-029 While Reset is high, all outputs take these values: Dout=0, Dout_Valid=0, Byte=0, Byte_Valid=0, Locked=0, Sync_Err_Cnt=0.
REQ-030 While Reset is high, internal state takes these values: h=5'b10101, sr=0, c=0, good=0, bad=0, FSM=HUNT.
REQ-031 Reset asserted mid-frame or in LOCKED takes effect immediately and asynchronously; framing restarts from HUNT after release.

Verification
REQ-032 After reset, valid Din = 0,0,0 -> Dout = 0,0,1 on the following three cycles, with Dout_Valid high.
REQ-033 Scrambler to block loopback, both reset together, Din_Valid low for the first cycle after release, then high -> Dout equals the scrambler's D1 input delayed by 2 cycles, for 1000 random bits.
REQ-034 Loopback with the descrambler's h forced to 5'b00000 -> Dout is correct from the 6th valid bit onward.
REQ-035 Defaults; frames of A5 + 4 random bytes, preceded by 13 random bits -> Locked rises at the end of the 2nd sync; subsequent payload bytes appear on Byte with one Byte_Valid pulse each; Sync_Err_Cnt stays 0.
REQ-036 Locked stream, one corrupted sync, then a good sync -> Locked stays 1, Sync_Err_Cnt=1, bytes continue; two consecutive corrupted syncs -> Locked falls after the 2nd, Sync_Err_Cnt=3.
REQ-037 Din_Valid toggled randomly 50% in a locked stream -> byte contents are unchanged and no Byte_Valid occurs in an invalid cycle; Reset pulsed mid-frame -> all outputs return to reset values and relock takes 2 frames.

Source files
------------

// File: rtl/descramble_framer.sv
// Five-tap self-synchronising descrambler feeding a sync-word framer (HUNT/VERIFY/LOCKED).
// Outputs are registered with one cycle of latency; Din_Valid low freezes all framing state.
module descramble_framer #(
  parameter logic [7:0] SYNC_WORD     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         LOCK_CNT      = 2,
  parameter int         UNLOCK_CNT    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Din,
  input  logic       Din_Valid,
  output logic       Dout,
  output logic       Dout_Valid,
  output logic [7:0] Byte,
  output logic       Byte_Valid,
  output logic       Locked,
  output logic [7:0] Sync_Err_Cnt
);

  localparam int FRAME_BITS = 8 * (PAYLOAD_BYTES + 1);
  localparam int CW         = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_POS = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] PAY_END  = CW'(8 * PAYLOAD_BYTES);
  localparam logic [2:0]    LOCK_N   = 3'(LOCK_CNT);
  localparam logic [2:0]    UNLOCK_N = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t        state;
  logic [4:0]    h;
  logic [7:0]    sr;
  logic [CW-1:0] c;
  logic [2:0]    good;
  logic [2:0]    bad;

  logic          d;
  logic [7:0]    sr_next;
  logic          sync_ok;
  logic          at_last;
  logic          sync_miss;
  logic [CW-1:0] c_next;
  logic [2:0]    good_inc;
  logic [2:0]    bad_inc;

  assign d         = Din ^ h[4] ^ h[3] ^ h[1] ^ h[0];
  assign sr_next   = {sr[6:0], d};
  assign sync_ok   = (sr_next == SYNC_WORD);
  assign at_last   = (c == LAST_POS);
  assign c_next    = at_last ? '0 : c + CW'(1);
  assign good_inc  = good + 3'd1;
  assign bad_inc   = bad + 3'd1;
  // Only the sync slot of an aligned frame can miss; HUNT never counts errors.
  assign sync_miss = Din_Valid && at_last && !sync_ok && (state != HUNT);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      h            <= 5'b10101;
      sr           <= '0;
      c            <= '0;
      good         <= '0;
      bad          <= '0;
      state        <= HUNT;
      Dout         <= 1'b0;
      Dout_Valid   <= 1'b0;
      Byte         <= '0;
      Byte_Valid   <= 1'b0;
      Locked       <= 1'b0;
      Sync_Err_Cnt <= '0;
    end else begin
      Dout_Valid <= Din_Valid;
      Byte_Valid <= 1'b0;
      if (sync_miss && Sync_Err_Cnt != 8'hFF)
        Sync_Err_Cnt <= Sync_Err_Cnt + 8'd1;
      if (Din_Valid) begin
        h    <= {h[3:0], Din};
        Dout <= d;
        sr   <= sr_next;
        c    <= c_next;
        case (state)
          HUNT: begin
            if (sync_ok) begin
              c    <= '0;
              good <= 3'd1;
              if (LOCK_CNT == 1) begin
                state  <= LOCKED;
                Locked <= 1'b1;
                bad    <= '0;
              end else begin
                state <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (at_last) begin
              if (sync_ok) begin
                good <= good_inc;
                if (good_inc == LOCK_N) begin
                  state  <= LOCKED;
                  Locked <= 1'b1;
                  bad    <= '0;
                end
              end else begin
                state <= HUNT;
              end
            end
          end
          LOCKED: begin
            if (c < PAY_END && c[2:0] == 3'd7) begin
              Byte       <= sr_next;
              Byte_Valid <= 1'b1;
            end
            if (at_last) begin
              if (sync_ok) begin
                bad <= '0;
              end else begin
                bad <= bad_inc;
                if (bad_inc == UNLOCK_N) begin
                  state  <= HUNT;
                  Locked <= 1'b0;
                end
              end
            end
          end
          default: begin
            state  <= HUNT;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
